// File: rtl/ibex_rf_write_ctrl.sv
// Register-file write-port initiator: merges execute and load writebacks with a
// one-entry skid buffer, tracks outstanding load destinations, raises ID hazards.
module ibex_rf_write_ctrl #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxLoads  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_issue_i,
  input  logic [4:0]           lsu_rd_i,
  output logic                 lsu_ready_o,
  input  logic                 lsu_resp_valid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  input  logic [4:0]           id_raddr_a_i,
  input  logic [4:0]           id_raddr_b_i,
  input  logic                 id_rs_a_used_i,
  input  logic                 id_rs_b_used_i,
  output logic                 stall_id_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  localparam int unsigned PtrW = (MaxLoads > 1) ? $clog2(MaxLoads) : 1;

  logic [4:0]           fifo_rd_q [MaxLoads];
  logic [MaxLoads-1:0]  fifo_vld_q, fifo_vld_d;
  logic [PtrW-1:0]      rptr_q, rptr_d, wptr_q, wptr_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [4:0]           skid_addr_q;
  logic [DataWidth-1:0] skid_data_q;
  logic                 err_q, err_d;

  logic       fifo_full, fifo_empty, pop, issue_ok;
  logic [4:0] head_rd;
  logic       waw, fifo_hit_a, fifo_hit_b, hit_a, hit_b;
  logic       ex_accept, ex_direct, ex_legal, skid_load, skid_drain;

  function automatic logic addr_legal(input logic [4:0] a);
    return !(RV32E && a[4]);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxLoads - 1)) return '0;
    else return p + PtrW'(1);
  endfunction

  assign fifo_full  = &fifo_vld_q;
  assign fifo_empty = ~|fifo_vld_q;
  assign head_rd    = fifo_rd_q[rptr_q];
  assign pop        = lsu_resp_valid_i && !fifo_empty;

  assign lsu_ready_o = !fifo_full || lsu_resp_valid_i;
  assign issue_ok    = lsu_issue_i && lsu_ready_o;

  // Destination match against every outstanding load (head still counts while popping)
  always_comb begin
    waw        = 1'b0;
    fifo_hit_a = 1'b0;
    fifo_hit_b = 1'b0;
    for (int i = 0; i < int'(MaxLoads); i++) begin
      if (fifo_vld_q[i]) begin
        if (fifo_rd_q[i] == ex_waddr_i)   waw        = 1'b1;
        if (fifo_rd_q[i] == id_raddr_a_i) fifo_hit_a = 1'b1;
        if (fifo_rd_q[i] == id_raddr_b_i) fifo_hit_b = 1'b1;
      end
    end
    waw = waw && (ex_waddr_i != 5'd0);
  end

  assign hit_a = id_rs_a_used_i && (id_raddr_a_i != 5'd0) &&
                 (fifo_hit_a || (skid_valid_q && skid_addr_q == id_raddr_a_i));
  assign hit_b = id_rs_b_used_i && (id_raddr_b_i != 5'd0) &&
                 (fifo_hit_b || (skid_valid_q && skid_addr_q == id_raddr_b_i));
  assign stall_id_o = hit_a || hit_b;

  assign ex_ready_o = !waw && !(skid_valid_q && lsu_resp_valid_i);
  assign ex_accept  = ex_we_i && ex_ready_o;
  assign ex_legal   = addr_legal(ex_waddr_i);
  assign ex_direct  = ex_accept && !lsu_resp_valid_i && !skid_valid_q;
  assign skid_drain = skid_valid_q && !lsu_resp_valid_i;
  // Illegal (RV32E) execute writes are consumed at acceptance and never parked
  assign skid_load  = ex_accept && !ex_direct && ex_legal;

  // Port arbitration: load response, then skid, then direct execute write
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (lsu_resp_valid_i) begin
      if (!fifo_empty) begin
        rf_waddr_o = head_rd;
        rf_wdata_o = lsu_rdata_i;
        rf_we_o    = !lsu_err_i && (head_rd != 5'd0) && addr_legal(head_rd);
      end
    end else if (skid_valid_q) begin
      rf_waddr_o = skid_addr_q;
      rf_wdata_o = skid_data_q;
      rf_we_o    = (skid_addr_q != 5'd0);
    end else if (ex_direct) begin
      rf_waddr_o = ex_waddr_i;
      rf_wdata_o = ex_wdata_i;
      rf_we_o    = (ex_waddr_i != 5'd0) && ex_legal;
    end
  end

  always_comb begin
    fifo_vld_d = fifo_vld_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    if (pop) begin
      fifo_vld_d[rptr_q] = 1'b0;
      rptr_d             = ptr_inc(rptr_q);
    end
    if (issue_ok) begin
      fifo_vld_d[wptr_q] = 1'b1;
      wptr_d             = ptr_inc(wptr_q);
    end
  end

  assign skid_valid_d = skid_load || (skid_valid_q && !skid_drain);

  assign err_d = (lsu_issue_i && !lsu_ready_o) ||
                 (lsu_resp_valid_i && fifo_empty) ||
                 (ex_accept && !ex_legal) ||
                 (pop && !lsu_err_i && !addr_legal(head_rd));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxLoads); i++) fifo_rd_q[i] <= '0;
      fifo_vld_q   <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      if (issue_ok) fifo_rd_q[wptr_q] <= lsu_rd_i;
      fifo_vld_q   <= fifo_vld_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      skid_valid_q <= skid_valid_d;
      if (skid_load) begin
        skid_addr_q <= ex_waddr_i;
        skid_data_q <= ex_wdata_i;
      end
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_ibex_rf_write_ctrl.sv
// Directed-vector bench for ibex_rf_write_ctrl (RV32E=1, MaxLoads=2).
module tb_ibex_rf_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        ex_ready;
  logic        lsu_issue;
  logic [4:0]  lsu_rd;
  logic        lsu_ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        lsu_err;
  logic [4:0]  raddr_a, raddr_b;
  logic        used_a, used_b;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  ibex_rf_write_ctrl #(.RV32E(1'b1), .DataWidth(32), .MaxLoads(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_issue_i(lsu_issue), .lsu_rd_i(lsu_rd), .lsu_ready_o(lsu_ready),
    .lsu_resp_valid_i(resp_valid), .lsu_rdata_i(rdata), .lsu_err_i(lsu_err),
    .id_raddr_a_i(raddr_a), .id_raddr_b_i(raddr_b),
    .id_rs_a_used_i(used_a), .id_rs_b_used_i(used_b),
    .stall_id_o(stall), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ex_we = 0; ex_waddr = 0; ex_wdata = 0; lsu_issue = 0; lsu_rd = 0;
    resp_valid = 0; rdata = 0; lsu_err = 0;
    raddr_a = 0; raddr_b = 0; used_a = 0; used_b = 0;
  endtask

  // Advance to 1 time unit after the next rising edge, then let inputs settle
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_bad++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ex_ready got %b want 1", ex_ready); end
    n_cmp++; if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_lsu_ready got %b want 1", lsu_ready); end
    step(); step();
    @(negedge clk); rst_n = 1;
    step();
  endtask

  task automatic test_back_to_back();
    ex_we = 1; ex_waddr = 5; ex_wdata = 32'h11; #1;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h11}) begin n_bad++;
      $display("FAIL b2b_first got we=%b a=%0d d=%h want 1/5/11", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if ({ex_ready, stall} !== 2'b10) begin n_bad++;
      $display("FAIL b2b_first_rdy got rdy=%b stall=%b want 1/0", ex_ready, stall); end
    step();
    ex_waddr = 6; ex_wdata = 32'h22; #1;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h22}) begin n_bad++;
      $display("FAIL b2b_second got we=%b a=%0d d=%h want 1/6/22", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if ({ex_ready, stall} !== 2'b10) begin n_bad++;
      $display("FAIL b2b_second_rdy got rdy=%b stall=%b want 1/0", ex_ready, stall); end
    step(); idle(); #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_we got %b want 0", rf_we); end
  endtask

  task automatic test_collision();
    lsu_issue = 1; lsu_rd = 7; step();
    lsu_issue = 0; ex_we = 1; ex_waddr = 8; ex_wdata = 32'hAA;
    resp_valid = 1; rdata = 32'hDEAD; #1;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hDEAD}) begin n_bad++;
      $display("FAIL coll_load got we=%b a=%0d d=%h want 1/7/dead", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL coll_ex_ready got %b want 1", ex_ready); end
    step(); idle(); raddr_b = 8; used_b = 1; #1;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'hAA}) begin n_bad++;
      $display("FAIL coll_skid got we=%b a=%0d d=%h want 1/8/aa", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL coll_skid_stall got %b want 1", stall); end
    step(); #1;
    n_cmp++; if ({rf_we, stall} !== 2'b00) begin n_bad++;
      $display("FAIL coll_drained got we=%b stall=%b want 0/0", rf_we, stall); end
    idle();
  endtask

  task automatic test_raw_stall();
    lsu_issue = 1; lsu_rd = 9; step();
    lsu_issue = 0; raddr_a = 9; used_a = 1; ex_we = 1; ex_waddr = 9; ex_wdata = 32'h5; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall got %b want 1", stall); end
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL raw_waw_ready got %b want 0", ex_ready); end
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL raw_no_write got %b want 0", rf_we); end
    step(); ex_we = 0; resp_valid = 1; rdata = 32'h99; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall_resp got %b want 1", stall); end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin n_bad++;
      $display("FAIL raw_resp got we=%b a=%0d d=%h want 1/9/99", rf_we, rf_waddr, rf_wdata); end
    step(); resp_valid = 0; ex_we = 1; #1;
    n_cmp++; if ({stall, ex_ready} !== 2'b01) begin n_bad++;
      $display("FAIL raw_cleared got stall=%b rdy=%b want 0/1", stall, ex_ready); end
    step(); idle();
  endtask

  task automatic test_fifo_full();
    lsu_issue = 1; lsu_rd = 1; step();
    lsu_rd = 2; step();
    lsu_issue = 0; #1;
    n_cmp++; if (lsu_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", lsu_ready); end
    lsu_issue = 1; lsu_rd = 4; step();
    lsu_issue = 0; #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL full_drop_err got %b want 1", err); end
    lsu_issue = 1; lsu_rd = 3; resp_valid = 1; rdata = 32'h1111; #1;
    n_cmp++; if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_ready got %b want 1", lsu_ready); end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h1111}) begin n_bad++;
      $display("FAIL full_resp1 got we=%b a=%0d d=%h want 1/1/1111", rf_we, rf_waddr, rf_wdata); end
    step(); lsu_issue = 0; rdata = 32'h2222; #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_pop_err got %b want 0", err); end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h2222}) begin n_bad++;
      $display("FAIL full_resp2 got we=%b a=%0d d=%h want 1/2/2222", rf_we, rf_waddr, rf_wdata); end
    step(); rdata = 32'h3333; #1;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h3333}) begin n_bad++;
      $display("FAIL full_resp3 got we=%b a=%0d d=%h want 1/3/3333", rf_we, rf_waddr, rf_wdata); end
    step(); idle(); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_drain_err got %b want 0", err); end
  endtask

  task automatic test_load_err();
    lsu_issue = 1; lsu_rd = 3; step();
    lsu_issue = 0; raddr_a = 3; used_a = 1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lerr_stall got %b want 1", stall); end
    resp_valid = 1; lsu_err = 1; rdata = 32'hBAD; #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL lerr_we got %b want 0", rf_we); end
    step(); resp_valid = 0; lsu_err = 0; #1;
    n_cmp++; if ({stall, err} !== 2'b00) begin n_bad++;
      $display("FAIL lerr_after got stall=%b err=%b want 0/0", stall, err); end
    resp_valid = 1; rdata = 32'h77; #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL empty_resp_we got %b want 0", rf_we); end
    step(); resp_valid = 0; #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL empty_resp_err got %b want 1", err); end
    step();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL empty_resp_pulse got %b want 0", err); end
    idle();
  endtask

  task automatic test_x0_rv32e();
    ex_we = 1; ex_waddr = 0; ex_wdata = 32'h55; #1;
    n_cmp++; if ({rf_we, ex_ready} !== 2'b01) begin n_bad++;
      $display("FAIL x0 got we=%b rdy=%b want 0/1", rf_we, ex_ready); end
    step(); ex_waddr = 20; ex_wdata = 32'h66; #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL x0_err got %b want 0", err); end
    n_cmp++; if ({rf_we, ex_ready} !== 2'b01) begin n_bad++;
      $display("FAIL rv32e got we=%b rdy=%b want 0/1", rf_we, ex_ready); end
    step(); ex_we = 0; #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rv32e_err got %b want 1", err); end
    step();
    n_cmp++; if ({err, rf_we} !== 2'b00) begin n_bad++;
      $display("FAIL rv32e_after got err=%b we=%b want 0/0", err, rf_we); end
    idle();
  endtask

  task automatic test_reset_mid();
    lsu_issue = 1; lsu_rd = 10; step();
    lsu_rd = 11; step();
    lsu_issue = 0; raddr_a = 10; used_a = 1; #1;
    n_cmp++; if ({lsu_ready, stall} !== 2'b01) begin n_bad++;
      $display("FAIL mid_pre got rdy=%b stall=%b want 0/1", lsu_ready, stall); end
    rst_n = 0; #1;
    n_cmp++; if ({lsu_ready, stall} !== 2'b10) begin n_bad++;
      $display("FAIL mid_rst got rdy=%b stall=%b want 1/0", lsu_ready, stall); end
    @(negedge clk); rst_n = 1;
    step(); raddr_a = 11; #1;
    n_cmp++; if ({lsu_ready, stall, rf_we} !== 3'b100) begin n_bad++;
      $display("FAIL mid_after got rdy=%b stall=%b we=%b want 1/0/0", lsu_ready, stall, rf_we); end
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_collision();
    test_raw_stall();
    test_fifo_full();
    test_load_err();
    test_x0_rv32e();
    test_reset_mid();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
